decoder_onehot_seq: RTL

- Parametrised N-to-2^N one-hot decoder with registered outputs, enable and load.
- Besides plain decoding, it has an auto-scan sequencer mode. The one-hot output walks up or down through all lines at a programmable rate, with a wrap pulse each time it rolls over.
- Drives row/bank selects and scan strobes in larger datapaths; intended replacement for the fixed-width gate-level decoders.

---
 rtl/decoder_onehot_seq.sv | 138 +++++++++++++
 1 files changed

// File: rtl/decoder_onehot_seq.sv
// decoder_onehot_seq: N-to-2^N one-hot decoder with a built-in auto-scan sequencer.
// Latency: 1 cycle from in/ld/mode/e to out/idx/wrap (all outputs registered).
// Backpressure: none. The block is free-running, and e=0 freezes sequencing and blanks out.
//
// Ports:
//   clk   - rising-edge clock
//   reset - asynchronous active-low reset (0 = in reset)
//   e     - enable; 0 holds idx/cnt and forces out to all-zero
//   in    - decode address in direct mode, load value when ld=1
//   ld    - load idx from in; overrides enable and mode
//   mode  - 00 direct, 01 scan up, 10 scan down, 11 hold
//   out   - registered one-hot (or all-zero) select, 2**N lines
//   idx   - registered current index
//   wrap  - one-cycle pulse when a scan step rolls over the end of the range
//
// Parameters: N is the select width (1..6). DIV is the number of scan-mode cycles per step (>=1).

`timescale 1ns/1ps

module decoder_onehot_seq #(
  parameter int N   = 3,
  parameter int DIV = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                e,
  input  logic [N-1:0]        in,
  input  logic                ld,
  input  logic [1:0]          mode,
  output logic [(2**N)-1:0]   out,
  output logic [N-1:0]        idx,
  output logic                wrap
);

  localparam int OUTS = 2**N;
  // The divider counter needs at least one bit, even when DIV=1 and it never leaves 0.
  localparam int CW   = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
  localparam logic [N-1:0]  IDX_MAX  = N'(OUTS - 1);
  localparam logic [N-1:0]  IDX_ONE  = N'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    MODE_DIRECT = 2'b00,
    MODE_UP     = 2'b01,
    MODE_DOWN   = 2'b10,
    MODE_HOLD   = 2'b11
  } mode_e;

  mode_e            mode_in;
  mode_e            mode_q;
  logic [N-1:0]     idx_q,  idx_d;
  logic [CW-1:0]    cnt_q,  cnt_d;
  logic             wrap_q, wrap_d;
  logic [OUTS-1:0]  out_q,  out_d;

  assign mode_in = mode_e'(mode);

  // Next-state selection in strict priority: load, enable, mode change, then per-mode action.
  always_comb begin
    idx_d  = idx_q;
    cnt_d  = cnt_q;
    wrap_d = 1'b0;

    if (ld) begin
      idx_d = in;
      cnt_d = '0;
    end else if (!e) begin
      // Frozen. idx/cnt hold and wrap stays low.
    end else if (mode_in != mode_q) begin
      // A mode change restarts the divider so the first scan step lands a full DIV
      // edges later. Entering direct mode takes the address immediately.
      cnt_d = '0;
      if (mode_in == MODE_DIRECT) begin
        idx_d = in;
      end
    end else begin
      unique case (mode_in)
        MODE_DIRECT: begin
          idx_d = in;
          cnt_d = '0;
        end
        MODE_UP: begin
          // cnt never exceeds DIV-1, so "not last" is the same as cnt < DIV-1.
          if (cnt_q != CNT_LAST) begin
            cnt_d = cnt_q + CNT_ONE;
          end else begin
            cnt_d  = '0;
            idx_d  = idx_q + IDX_ONE;  // natural N-bit wrap gives mod OUTS
            wrap_d = (idx_q == IDX_MAX);
          end
        end
        MODE_DOWN: begin
          if (cnt_q != CNT_LAST) begin
            cnt_d = cnt_q + CNT_ONE;
          end else begin
            cnt_d  = '0;
            idx_d  = idx_q - IDX_ONE;
            wrap_d = (idx_q == '0);
          end
        end
        MODE_HOLD: begin
          // idx/cnt hold.
        end
        default: begin
          // All encodings are covered above.
        end
      endcase
    end

    // out is decoded from the next index so that it tracks idx on the same edge.
    out_d = e ? (OUTS'(1) << idx_d) : '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx_q  <= '0;
      cnt_q  <= '0;
      wrap_q <= 1'b0;
      out_q  <= '0;
      mode_q <= MODE_DIRECT;
    end else begin
      idx_q  <= idx_d;
      cnt_q  <= cnt_d;
      wrap_q <= wrap_d;
      out_q  <= out_d;
      // Track the raw mode every edge, even when frozen or loading. A change that
      // happens while e=0 or ld=1 is therefore not seen as a change afterwards.
      mode_q <= mode_in;
    end
  end

  assign out  = out_q;
  assign idx  = idx_q;
  assign wrap = wrap_q;

endmodule
